// File: rtl/flatten_streamer_if.sv
// flatten_streamer_if: pooled-sample input and dense-layer feature/handshake bundle
interface flatten_streamer_if #(
    parameter int DATA_WIDTH = 20
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_ready;
    logic                         dense_start;
    logic signed [DATA_WIDTH-1:0] feature_out;
    logic                         feature_valid;
    logic                         dense_done;
    logic                         frame_done;

    modport master (
        output in_valid, in_data, dense_done,
        input  in_ready, dense_start, feature_out, feature_valid, frame_done
    );

    modport slave (
        input  in_valid, in_data, dense_done,
        output in_ready, dense_start, feature_out, feature_valid, frame_done
    );
endinterface

// File: rtl/flatten_streamer.sv
// flatten_streamer: buffers one pooled frame (channel fastest) and replays it channel-major to the dense layer
module flatten_streamer #(
    parameter int IMG_H      = 13,
    parameter int IMG_W      = 13,
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 20,
    parameter int GAP        = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    flatten_streamer_if.slave  bus
);
    localparam int N  = IMG_H * IMG_W * CHANNELS;
    localparam int HW = IMG_H * IMG_W;
    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {FILL, ARM, STREAM, WAIT_DONE} state_t;

    state_t                       state_q;
    logic [AW-1:0]                wr_c_q, wr_r_q, wr_ch_q, row_off_q, ch_off_q;
    logic [AW-1:0]                wr_c_d, wr_r_d, wr_ch_d, row_off_d, ch_off_d;
    logic [AW-1:0]                rd_idx_q;
    logic [3:0]                   gap_q;
    logic                         dense_start_q, feature_valid_q, frame_done_q;
    logic signed [DATA_WIDTH-1:0] feature_out_q;
    logic signed [DATA_WIDTH-1:0] mem [N];
    logic                         wr_en, rd_en, last_ch, last_c, last_r, last_in, last_rd;
    logic [AW-1:0]                wr_addr;

    assign wr_en   = state_q == FILL && bus.in_valid;
    assign rd_en   = state_q == ARM || (state_q == STREAM && gap_q == 4'd0);
    assign last_ch = wr_ch_q == AW'(CHANNELS - 1);
    assign last_c  = wr_c_q == AW'(IMG_W - 1);
    assign last_r  = wr_r_q == AW'(IMG_H - 1);
    assign last_in = last_ch && last_c && last_r;
    assign last_rd = rd_idx_q == AW'(N - 1);
    assign wr_addr = ch_off_q + row_off_q + wr_c_q;

    assign bus.in_ready      = state_q == FILL;
    assign bus.dense_start   = dense_start_q;
    assign bus.feature_out   = feature_out_q;
    assign bus.feature_valid = feature_valid_q;
    assign bus.frame_done    = frame_done_q;

    // Next write position: channel wraps into column, column wraps into row; offsets track the products.
    always_comb begin
        wr_ch_d   = last_ch ? '0 : wr_ch_q + 1'b1;
        ch_off_d  = last_ch ? '0 : ch_off_q + AW'(HW);
        wr_c_d    = !last_ch ? wr_c_q : (last_c ? '0 : wr_c_q + 1'b1);
        wr_r_d    = !(last_ch && last_c) ? wr_r_q : (last_r ? '0 : wr_r_q + 1'b1);
        row_off_d = !(last_ch && last_c) ? row_off_q : (last_r ? '0 : row_off_q + AW'(IMG_W));
    end

    // Frame store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.in_data;
    end

    // Control FSM with the synchronous read port folded into the registered feature output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= FILL;
            wr_c_q          <= '0;
            wr_r_q          <= '0;
            wr_ch_q         <= '0;
            row_off_q       <= '0;
            ch_off_q        <= '0;
            rd_idx_q        <= '0;
            gap_q           <= '0;
            dense_start_q   <= 1'b0;
            feature_valid_q <= 1'b0;
            feature_out_q   <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            frame_done_q    <= 1'b0;
            feature_valid_q <= rd_en;
            if (rd_en) begin
                feature_out_q <= mem[rd_idx_q];
                rd_idx_q      <= last_rd ? '0 : rd_idx_q + 1'b1;
                gap_q         <= 4'(GAP);
            end else if (gap_q != 4'd0) begin
                gap_q <= gap_q - 1'b1;
            end
            case (state_q)
                FILL: if (wr_en) begin
                    wr_c_q    <= wr_c_d;
                    wr_r_q    <= wr_r_d;
                    wr_ch_q   <= wr_ch_d;
                    row_off_q <= row_off_d;
                    ch_off_q  <= ch_off_d;
                    if (last_in) begin
                        state_q       <= ARM;
                        dense_start_q <= 1'b1;
                    end
                end
                ARM:       state_q <= STREAM;
                STREAM:    if (rd_en && last_rd) state_q <= WAIT_DONE;
                WAIT_DONE: if (bus.dense_done) begin
                    state_q       <= FILL;
                    dense_start_q <= 1'b0;
                    frame_done_q  <= 1'b1;
                end
                default:   state_q <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_flatten_streamer.sv
// tb_flatten_streamer: directed checks of ordering, timing, gap, ignored inputs, back-to-back and reset
module tb_flatten_streamer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n0 = 0;
    int   n2 = 0;
    int   v0 [4096];
    int   t0 [4096];
    int   v2 [1024];
    int   t2 [1024];

    flatten_streamer_if #(.DATA_WIDTH(20)) bus0 ();
    flatten_streamer_if #(.DATA_WIDTH(20)) bus2 ();

    flatten_streamer #(.GAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    flatten_streamer #(.GAP(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Beat recorder: value and cycle of every valid feature on each instance.
    always @(negedge clk) begin
        if (bus0.feature_valid) begin
            if (n0 < 4096) begin
                v0[n0] = int'(bus0.feature_out);
                t0[n0] = cyc;
            end
            n0++;
        end
        if (bus2.feature_valid) begin
            if (n2 < 1024) begin
                v2[n2] = int'(bus2.feature_out);
                t2[n2] = cyc;
            end
            n2++;
        end
    end

    function automatic int expv(input int i, input int off);
        return (i / 169) * 1000 + (i % 169) + off;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input bit en0, input bit en2, input int off, output int last);
        @(posedge clk);
        #1;
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 13; c++)
                for (int ch = 0; ch < 4; ch++) begin
                    bus0.in_valid = en0;
                    bus2.in_valid = en2;
                    bus0.in_data  = 20'(ch * 1000 + r * 13 + c + off);
                    bus2.in_data  = 20'(ch * 1000 + r * 13 + c + off);
                    last = cyc;
                    @(posedge clk);
                    #1;
                end
        bus0.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
    endtask

    task automatic finish0(input int b, input int off, input int last);
        int errs = 0;
        wait_until(last + 690);
        bus0.dense_done = 1'b1;
        @(posedge clk);
        #1;
        bus0.dense_done = 1'b0;
        @(negedge clk);
        chk("done_start_low", 32'(bus0.dense_start), 0);
        chk("done_pulse", 32'(bus0.frame_done), 1);
        chk("done_ready", 32'(bus0.in_ready), 1);
        chk("beat_count", n0 - b, 676);
        chk("first_beat_cyc", t0[b] - last, 2);
        chk("last_beat_cyc", t0[b + 675] - last, 677);
        for (int i = 0; i < 676; i++) if (v0[b + i] != expv(i, off)) errs++;
        chk("order_vals", errs, 0);
        chk("beat169", v0[b + 169], 1000 + off);
        chk("beat675", v0[b + 675], 3168 + off);
        chk("hold_last", bus0.feature_out, 3168 + off);
        @(negedge clk);
        chk("pulse_once", 32'(bus0.frame_done), 0);
    endtask

    initial begin
        int last, b0, b2, errs;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.dense_done = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.dense_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus0.in_ready), 1);
        chk("rst_start", 32'(bus0.dense_start), 0);
        chk("rst_valid", 32'(bus0.feature_valid), 0);
        chk("rst_fout", bus0.feature_out, 0);
        chk("rst_fdone", 32'(bus0.frame_done), 0);
        rst_n = 1'b1;
        // Frame A on both instances: ordering and timing, then gap spacing.
        b0 = n0;
        b2 = n2;
        fill(1'b1, 1'b1, 0, last);
        @(negedge clk);
        chk("arm_start", 32'(bus0.dense_start), 1);
        chk("arm_ready", 32'(bus0.in_ready), 0);
        chk("arm_no_beat", 32'(bus0.feature_valid), 0);
        chk("beat0_val", 32'(n0 - b0), 0);
        finish0(b0, 0, last);
        wait_until(last + 2030);
        errs = 0;
        for (int i = 0; i < 676; i++) if (v2[b2 + i] != expv(i, 0)) errs++;
        chk("gap_count", n2 - b2, 676);
        chk("gap_first", t2[b2] - last, 2);
        chk("gap_second", t2[b2 + 1] - last, 5);
        chk("gap_last", t2[b2 + 675] - last, 2 + 675 * 3);
        chk("gap_vals", errs, 0);
        chk("gap_wait_start", 32'(bus2.dense_start), 1);
        bus2.dense_done = 1'b1;
        @(posedge clk);
        #1;
        bus2.dense_done = 1'b0;
        @(negedge clk);
        chk("gap_done_pulse", 32'(bus2.frame_done), 1);
        chk("gap_done_start", 32'(bus2.dense_start), 0);
        // Frame B: +5 pattern, junk input and early done during the stream.
        b0 = n0;
        fill(1'b1, 1'b0, 5, last);
        bus0.in_valid = 1'b1;
        bus0.in_data  = 20'h7FFFF;
        wait_until(last + 100);
        bus0.dense_done = 1'b1;
        @(posedge clk);
        #1;
        bus0.dense_done = 1'b0;
        @(negedge clk);
        chk("early_done_start", 32'(bus0.dense_start), 1);
        chk("early_done_pulse", 32'(bus0.frame_done), 0);
        chk("stream_ready", 32'(bus0.in_ready), 0);
        wait_until(last + 685);
        bus0.in_valid = 1'b0;
        finish0(b0, 5, last);
        // Frame C: plain pattern again, proving no residue and write index restart.
        b0 = n0;
        fill(1'b1, 1'b0, 0, last);
        finish0(b0, 0, last);
        // Frame D: reset during beat 300.
        b0 = n0;
        fill(1'b1, 1'b0, 0, last);
        wait_until(last + 302);
        @(negedge clk);
        chk("beat300_valid", 32'(bus0.feature_valid), 1);
        chk("beat300_val", bus0.feature_out, expv(300, 0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", 32'(bus0.dense_start), 0);
        chk("mid_rst_valid", 32'(bus0.feature_valid), 0);
        chk("mid_rst_fout", bus0.feature_out, 0);
        chk("mid_rst_fdone", 32'(bus0.frame_done), 0);
        chk("mid_rst_ready", 32'(bus0.in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus0.in_ready), 1);
        chk("post_rst_valid", 32'(bus0.feature_valid), 0);
        // Frame E: full frame after the aborted one.
        b0 = n0;
        fill(1'b1, 1'b0, 7, last);
        finish0(b0, 7, last);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flatten_streamer.md
# flatten_streamer

Reorder buffer and feature transmitter between the pooling stage and the dense classifier. Accepts one 13x13x4 pooled frame in pooling output order (row, column, channel fastest) and stores it internally. Once the frame is complete, it streams the 676 features in flatten order (channel-major, `index = ch*H*W + r*W + c`) to the dense layer's `start` / `feature_in` / `feature_valid` port. Then it holds `start` until the dense layer reports `done`.

## Interface
- `IMG_H`, default 13, pooled map height
- `IMG_W`, default 13, pooled map width
- `CHANNELS`, default 4, pooled channels
- `DATA_WIDTH`, default 20, feature width (signed)
- `GAP`, default 0, idle cycles inserted after each emitted feature (0..15)
- `N` = `IMG_H*IMG_W*CHANNELS` (derived localparam, 676)
- `clk`  input  1  clock
- `rst_n`  input  1  reset; asynchronous, active-low
- `in_valid`  input  1  pooled sample present
- `in_data`  input  `DATA_WIDTH`  pooled sample (signed)
- `in_ready`  output  1  block accepting samples; a sample transfers when `in_valid && in_ready`
- `dense_start`  output  1  start level to the dense layer
- `feature_out`  output  `DATA_WIDTH`  streamed feature (signed)
- `feature_valid`  output  1  `feature_out` valid this cycle
- `dense_done`  input  1  dense layer done level
- `frame_done`  output  1  one-cycle pulse when the handshake for a frame completes

## Operation
- Storage: N x `DATA_WIDTH` RAM with one write port and a synchronous read port (1-cycle read latency).
- Write counters `wr_c` (0..`IMG_W`-1), `wr_r` (0..`IMG_H`-1) and `wr_ch` (0..`CHANNELS`-1), where `ch` is fastest, then `c`, then `r`.
- Write address is `wr_ch*IMG_H*IMG_W + wr_r*IMG_W + wr_c`, computed with registered offsets (no runtime multiply required).
- Read counter `rd_idx` runs 0..N-1 sequentially. It is paired with a `GAP` counter.
- FSM states: FILL, ARM, STREAM, WAIT_DONE. Reset state is FILL.
  - **FILL:** `in_ready`=1. Each transfer writes the RAM and advances the counters. The transfer of sample N-1 clears the counters and moves to ARM.
  - **ARM** (1 cycle): `dense_start`<=1; issue read of address 0; go to STREAM.
  - **STREAM:** the read issued in cycle t appears as `feature_out` with `feature_valid`=1 in cycle t+1. A new read is issued every `GAP`+1 cycles. After the read of index N-1 is issued, go to WAIT_DONE. That read's output beat completes in the following cycle.
  - **WAIT_DONE:** `dense_start` held at 1. When `dense_done` is sampled high, go to FILL: `dense_start`<=0 and `frame_done` pulses.
- `in_ready` is 0 in ARM, STREAM and WAIT_DONE. `in_valid` in those states is ignored and causes no write.
- `dense_done` is ignored outside WAIT_DONE.
- Exactly N `feature_valid` beats are emitted per frame, never more and never fewer.
- `feature_out` holds its last value when `feature_valid`=0.
- Reset values: `in_ready`=1 (FILL), `dense_start`=0, `feature_valid`=0, `feature_out`=0, `frame_done`=0, all counters 0. RAM contents are not reset.
- Reset asserted mid-frame (in any state) aborts the frame immediately. The next frame restarts at write index 0.

## Timing
- Let the last input transfer occur in cycle L.
  - Cycle L+1: ARM, `dense_start` rises.
  - Cycle L+2: first beat, feature index 0.
  - Beat k occurs in cycle L+2+k*(`GAP`+1).
  - The last beat is at L+2+(N-1)*(`GAP`+1). With `GAP`=0 this is L+677.
- The dense layer samples `dense_start` in L+1 and accepts beats from L+2, so it sees no lost beat.
- Let `dense_done` first be sampled high in cycle D. Then in D+1: `dense_start`=0, `frame_done`=1, `in_ready`=1.
- Earliest next-frame write is in cycle D+1.
- Throughput with `GAP`=0: N fill cycles + N+2 stream cycles + the dense layer's done latency.

## Test plan
- **Ordering:** send input sample (r,c,ch) with value `ch*1000 + r*13 + c`. Then beat i must equal `(i/169)*1000 + (i mod 169)`; for example beat 0=0, beat 168=168, beat 169=1000, beat 675=3168.
- **Cycle timing:** with `GAP`=0, last input in cycle L, check `dense_start` high at L+1, first beat at L+2, last beat at L+677, exactly 676 beats. Hold `dense_done` high at L+690 -> check `dense_start` low, `frame_done` pulse and `in_ready` high at L+691.
- **Gap:** `GAP`=2 -> beats spaced 3 cycles apart, last beat at L+2+675*3.
- **Ignored inputs:** drive `in_valid`=1 with value 0x7FFFF throughout the stream -> output identical to the ordering test; the next frame's first write goes to index 0. A `dense_done` pulse during STREAM has no effect.
- **Back-to-back:** two frames with distinct patterns (second frame = first + 5) -> the second stream equals the first + 5, with no residue from the first.
- **Reset mid-stream:** assert `rst_n`=0 at beat 300 -> all outputs at reset values immediately and `in_ready`=1 after release. A full new frame then streams correctly.
